// File: rtl/text_writer.sv
// Converts an ASCII byte stream into tilemem writes on a COLS x ROWS grid.
// Optional feature TEXT_WRITER_LINECLR_EN blanks each newly entered row.
`ifndef FONT_WIDTH
`define FONT_WIDTH 8
`endif

module text_writer #(
  parameter int         COLS   = 20,
  parameter int         ROWS   = 15,
  parameter int         ADDR_W = 9,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [`FONT_WIDTH-1:0] wr_data,
  output logic [4:0]             cursor_col,
  output logic [3:0]             cursor_row,
  output logic                   busy
);

  localparam int                FW        = `FONT_WIDTH;
  localparam logic [4:0]        LAST_COL  = 5'(COLS - 1);
  localparam logic [3:0]        LAST_ROW  = 4'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [FW-1:0]     BLANK_W   = FW'(BLANK);

`ifdef TEXT_WRITER_LINECLR_EN
  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_IDLE = 2'd1, S_LCLR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_IDLE = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [4:0]        col_q, col_d;
  logic [3:0]        row_q, row_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [FW-1:0]     wr_data_q, wr_data_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic [3:0]        row_inc;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] r, input logic [4:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  assign accept  = in_valid & in_ready_q;
  assign row_inc = (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    col_d     = col_q;
    row_d     = row_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_ptr_q;
        wr_data_d = BLANK_W;
        if (clr_ptr_q == LAST_CELL) begin
          clr_ptr_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr(row_q, col_q);
            wr_data_d = FW'(in_data);
            if (col_q == LAST_COL) begin
              col_d = 5'd0;
              row_d = row_inc;
            end else begin
              col_d = col_q + 5'd1;
            end
          end else begin
            case (in_data)
              8'h0D: col_d = 5'd0;
              8'h0A: row_d = row_inc;
              8'h08: begin
                // Backspace blanks the cell it moves onto; at column 0 it is a no-op.
                if (col_q != 5'd0) begin
                  col_d     = col_q - 5'd1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = cell_addr(row_q, col_q - 5'd1);
                  wr_data_d = BLANK_W;
                end
              end
              8'h0C: begin
                col_d     = 5'd0;
                row_d     = 4'd0;
                clr_ptr_d = '0;
                state_d   = S_CLEAR;
              end
              default: ;
            endcase
          end
`ifdef TEXT_WRITER_LINECLR_EN
          // Any row change out of IDLE means a new row was entered.
          if (state_d == S_IDLE && row_d != row_q) begin
            state_d   = S_LCLR;
            clr_ptr_d = cell_addr(row_d, 5'd0);
          end
`endif
        end
      end
`ifdef TEXT_WRITER_LINECLR_EN
      S_LCLR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_ptr_q;
        wr_data_d = BLANK_W;
        if (clr_ptr_q == cell_addr(row_q, LAST_COL)) begin
          clr_ptr_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
`endif
      default: state_d = S_CLEAR;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_CLEAR;
      clr_ptr_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: stimulus queues expected writes, a monitor checks them.
`ifndef FONT_WIDTH
`define FONT_WIDTH 8
`endif

module tb_text_writer;
  logic                   clk = 1'b0;
  logic                   resetn;
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   wr_en;
  logic [8:0]             wr_addr;
  logic [`FONT_WIDTH-1:0] wr_data;
  logic [4:0]             cursor_col;
  logic [3:0]             cursor_row;
  logic                   busy;

  always #5 clk = ~clk;

  text_writer dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  always @(negedge clk) begin
    if (resetn === 1'b1 && wr_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.addr !== wr_addr || e.data !== 8'(wr_data)) begin
          n_bad++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.addr = 9'(a);
    e.data = 8'(d);
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 300; i++) push_wr(i, 8'h20);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: got in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // newrow >= 0 means the byte enters that row; wa >= 0 means a write (wa, wd) is due.
  task automatic put(input logic [7:0] b, input int newrow, input int wa, input int wd);
    int c;
    wait_ready(c);
    if (wa >= 0) push_wr(wa, wd);
`ifdef TEXT_WRITER_LINECLR_EN
    if (newrow >= 0) for (int i = 0; i < 20; i++) push_wr(newrow * 20 + i, 8'h20);
`endif
    send(b);
    if (newrow >= 0) check("new_row", cursor_row, newrow);
  endtask

  initial begin
    int c;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);

    // Power-up clear
    push_clear();
    resetn = 1'b1;
    wait_ready(c);
    check("clear_cycles", c, 300);
    check("clear_busy", busy, 0);
    check("clear_col", cursor_col, 0);
    check("clear_row", cursor_row, 0);
    @(negedge clk); #1;
    check("clear_drained", exp_q.size(), 0);

    // "AB" back-to-back
    put("A", -1, 0, 8'h41);
    check("a_latency_en", wr_en, 1);
    check("a_latency_addr", wr_addr, 0);
    put("B", -1, 1, 8'h42);
    check("b_addr", wr_addr, 1);
    check("b_data", wr_data, 8'h42);
    check("ab_col", cursor_col, 2);

    // Move to 19/2 and wrap with 'Z'
    put(8'h0A, 1, -1, 0);
    put(8'h0A, 2, -1, 0);
    put(8'h0D, -1, -1, 0);
    check("cr_col", cursor_col, 0);
    check("lf_row", cursor_row, 2);
    for (int i = 0; i < 19; i++) put(8'(8'h61 + i), -1, 40 + i, 8'h61 + i);
    check("pre_z_col", cursor_col, 19);
    put("Z", 3, 59, 8'h5A);
    check("z_col", cursor_col, 0);
    check("z_row", cursor_row, 3);
`ifdef TEXT_WRITER_LINECLR_EN
    check("z_lclr_ready", in_ready, 0);
`endif

    // Reach 5/14, then CR LF wraps rows to 0/0; control junk is dropped
    for (int r = 4; r < 15; r++) put(8'h0A, r, -1, 0);
    for (int i = 0; i < 5; i++) put(8'(8'h30 + i), -1, 280 + i, 8'h30 + i);
    check("at_col5", cursor_col, 5);
    check("at_row14", cursor_row, 14);
    put(8'h0D, -1, -1, 0);
    put(8'h0A, 0, -1, 0);
    check("wrap_col", cursor_col, 0);
    check("wrap_row", cursor_row, 0);
    put(8'h07, -1, -1, 0);
    put(8'h80, -1, -1, 0);
    put(8'h7F, -1, -1, 0);
    check("drop_col", cursor_col, 0);
    check("drop_row", cursor_row, 0);
    repeat (25) tick();
    check("no_stray_writes", exp_q.size(), 0);

    // Form feed
    wait_ready(c);
    push_clear();
    send(8'h0C);
    check("ff_ready_low", in_ready, 0);
    check("ff_busy", busy, 1);
    check("ff_col", cursor_col, 0);
    check("ff_row", cursor_row, 0);
    wait_ready(c);
    check("ff_cycles", c, 300);

    // "X", BS, BS
    put("X", -1, 0, 8'h58);
    put(8'h08, -1, 0, 8'h20);
    check("bs_col", cursor_col, 0);
    put(8'h08, -1, -1, 0);
    check("bs0_col", cursor_col, 0);
    check("bs0_row", cursor_row, 0);

    // Printable at 19/14 wraps to 0/0
    for (int r = 1; r < 15; r++) put(8'h0A, r, -1, 0);
    for (int i = 0; i < 19; i++) put(8'(8'h41 + i), -1, 280 + i, 8'h41 + i);
    check("corner_col", cursor_col, 19);
    check("corner_row", cursor_row, 14);
    put("!", 0, 299, 8'h21);
    check("corner_wrap_col", cursor_col, 0);
    check("corner_wrap_row", cursor_row, 0);
    wait_ready(c);
    @(negedge clk); #1;
    check("corner_drained", exp_q.size(), 0);

    // Reset in the middle of a clear
    push_clear();
    send(8'h0C);
    c = 0;
    while (!(wr_en === 1'b1 && wr_addr == 9'd150) && c < 400) begin
      tick();
      c++;
    end
    check("reach_150", wr_addr, 150);
    resetn = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_busy", busy, 1);
    exp_q.delete();
    tick();
    resetn = 1'b1;
    push_clear();
    tick();
    check("restart_en", wr_en, 1);
    check("restart_addr", wr_addr, 0);
    wait_ready(c);
    check("restart_cycles", c, 299);
    @(negedge clk); #1;
    check("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
